// File: rtl/access_pkg.sv
// access_pkg: shared types and helpers for the memory-access stage.
//   mem_op_e / mem_size_e : instruction memory-op and access-size encodings
//   state_e               : access-stage FSM states
//   TL_* constants        : TileLink-UL opcodes used on channels A and D
//   CAUSE_* constants     : exception cause codes reported to writeback
//   lane_mask / replicate_wdata / is_misaligned : A-channel field helpers
package access_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // TileLink-UL opcodes
    localparam logic [2:0] TL_GET     = 3'd4;
    localparam logic [2:0] TL_PUTFULL = 3'd0;
    localparam logic [2:0] TL_ACK     = 3'd0;
    localparam logic [2:0] TL_ACKDATA = 3'd1;

    // Exception causes
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

    // Byte lanes touched: (2^(2^size) - 1) shifted to the address offset.
    function automatic logic [7:0] lane_mask(mem_size_e size, logic [2:0] off);
        logic [8:0] span;
        span = (9'd1 << (4'd1 << size)) - 9'd1;
        return span[7:0] << off;
    endfunction

    // TileLink carries store data on every lane; copy the LSB-aligned
    // operand so whichever lanes the mask selects hold the right bytes.
    function automatic logic [63:0] replicate_wdata(mem_size_e size, logic [63:0] wdata);
        logic [63:0] rep;
        case (size)
            SZ_BYTE: rep = {8{wdata[7:0]}};
            SZ_HALF: rep = {4{wdata[15:0]}};
            SZ_WORD: rep = {2{wdata[31:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic is_misaligned(mem_size_e size, logic [2:0] addr_lo);
        logic [2:0] low_bits;
        case (size)
            SZ_BYTE: low_bits = 3'b000;
            SZ_HALF: low_bits = 3'b001;
            SZ_WORD: low_bits = 3'b011;
            default: low_bits = 3'b111;
        endcase
        return (addr_lo & low_bits) != 3'b000;
    endfunction

endpackage

// File: rtl/access_stage_load_align.sv
// load_align: purely combinational load-data formatter.
//   d_data   in  64  raw beat from TileLink channel D
//   offset   in  3   byte offset of the access within the 8-byte beat
//   size     in  2   access size (mem_size_e)
//   sign_ext in  1   1 = sign-extend, 0 = zero-extend
//   data     out 64  right-aligned, extended load value
module load_align
    import access_pkg::*;
(
    input  logic [63:0] d_data,
    input  logic [2:0]  offset,
    input  mem_size_e   size,
    input  logic        sign_ext,
    output logic [63:0] data
);

    logic [63:0] shifted;

    // NOTE: every output of a combinational block gets a value on every path
    // (default or full case); a missed branch would infer a latch.
    always_comb begin
        shifted = d_data >> {offset, 3'b000};
        case (size)
            SZ_BYTE: data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
            SZ_HALF: data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_WORD: data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/access_stage.sv
// access_stage: memory-access pipeline stage between execute and writeback.
// Non-memory results pass through in one cycle; aligned loads/stores become a
// single-beat TileLink-UL Get/PutFullData with at most one in flight.
//   clk, rst                      clock, synchronous active-high reset
//   ex_*                          instruction from execute (held while stall=1)
//   stall                         stage busy, execute must hold
//   ma_valid, pc, rd, data        one-cycle retire pulse to writeback/monitor
//   exc, exc_cause                exception reported with the retiring op
//   a_*                           TileLink channel A (request)
//   d_*                           TileLink channel D (response)
module access_stage
    import access_pkg::*;
#(
    parameter int unsigned SRC_ID           = 0,
    parameter int unsigned SIGN_EXT_DEFAULT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [63:0] ex_pc,
    input  logic [4:0]  ex_rd,
    input  logic [63:0] ex_result,
    input  logic [63:0] ex_wdata,
    input  logic [1:0]  ex_op,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    output logic        stall,
    output logic        ma_valid,
    output logic [63:0] pc,
    output logic [4:0]  rd,
    output logic [63:0] data,
    output logic        exc,
    output logic [3:0]  exc_cause,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_opcode,
    output logic [2:0]  a_size,
    output logic [3:0]  a_source,
    output logic [63:0] a_address,
    output logic [7:0]  a_mask,
    output logic [63:0] a_data,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic        d_denied,
    input  logic [63:0] d_data
);

    state_e      state_q, state_d;

    // Captured memory op, held from IDLE until the response retires.
    mem_op_e     cap_op_q, cap_op_d;
    mem_size_e   cap_size_q, cap_size_d;
    logic        cap_unsigned_q, cap_unsigned_d;
    logic [63:0] cap_addr_q, cap_addr_d;
    logic [63:0] cap_wdata_q, cap_wdata_d;
    logic [63:0] cap_pc_q, cap_pc_d;
    logic [4:0]  cap_rd_q, cap_rd_d;

    // Writeback-facing registers.
    logic        ma_valid_q, ma_valid_d;
    logic [63:0] pc_q, pc_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] data_q, data_d;
    logic        exc_q, exc_d;
    logic [3:0]  cause_q, cause_d;

    logic [63:0] load_data;
    logic        load_sign_ext;
    logic        resp_fault;

    assign load_sign_ext = (SIGN_EXT_DEFAULT != 0) && !cap_unsigned_q;

    load_align u_load_align (
        .d_data   (d_data),
        .offset   (cap_addr_q[2:0]),
        .size     (cap_size_q),
        .sign_ext (load_sign_ext),
        .data     (load_data)
    );

    // A response with the wrong opcode for the request is reported as a fault.
    assign resp_fault = d_denied ||
                        (cap_op_q == OP_LOAD ? (d_opcode != TL_ACKDATA)
                                             : (d_opcode != TL_ACK));

    always_comb begin
        state_d        = state_q;
        cap_op_d       = cap_op_q;
        cap_size_d     = cap_size_q;
        cap_unsigned_d = cap_unsigned_q;
        cap_addr_d     = cap_addr_q;
        cap_wdata_d    = cap_wdata_q;
        cap_pc_d       = cap_pc_q;
        cap_rd_d       = cap_rd_q;
        ma_valid_d     = 1'b0;
        pc_d           = pc_q;
        rd_d           = rd_q;
        data_d         = data_q;
        exc_d          = exc_q;
        cause_d        = cause_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_op == OP_LOAD || ex_op == OP_STORE) begin
                        if (is_misaligned(mem_size_e'(ex_size), ex_result[2:0])) begin
                            // Trap without touching the bus.
                            ma_valid_d = 1'b1;
                            pc_d       = ex_pc;
                            rd_d       = 5'd0;
                            data_d     = 64'd0;
                            exc_d      = 1'b1;
                            cause_d    = (ex_op == OP_LOAD) ? CAUSE_LOAD_MISALIGNED
                                                            : CAUSE_STORE_MISALIGNED;
                        end else begin
                            cap_op_d       = (ex_op == OP_LOAD) ? OP_LOAD : OP_STORE;
                            cap_size_d     = mem_size_e'(ex_size);
                            cap_unsigned_d = ex_unsigned;
                            cap_addr_d     = ex_result;
                            cap_wdata_d    = ex_wdata;
                            cap_pc_d       = ex_pc;
                            cap_rd_d       = ex_rd;
                            state_d        = REQ;
                        end
                    end else begin
                        ma_valid_d = 1'b1;
                        pc_d       = ex_pc;
                        rd_d       = ex_rd;
                        data_d     = ex_result;
                        exc_d      = 1'b0;
                        cause_d    = 4'd0;
                    end
                end
            end

            REQ: begin
                if (a_ready) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                if (d_valid) begin
                    state_d    = IDLE;
                    ma_valid_d = 1'b1;
                    pc_d       = cap_pc_q;
                    if (resp_fault) begin
                        rd_d    = 5'd0;
                        data_d  = 64'd0;
                        exc_d   = 1'b1;
                        cause_d = (cap_op_q == OP_LOAD) ? CAUSE_LOAD_FAULT
                                                        : CAUSE_STORE_FAULT;
                    end else begin
                        rd_d    = (cap_op_q == OP_LOAD) ? cap_rd_q : 5'd0;
                        data_d  = (cap_op_q == OP_LOAD) ? load_data : 64'd0;
                        exc_d   = 1'b0;
                        cause_d = 4'd0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the capture registers are reset too, so the A-channel
            // fields read as zero after reset instead of holding stale X.
            state_q        <= IDLE;
            cap_op_q       <= OP_NONE;
            cap_size_q     <= SZ_BYTE;
            cap_unsigned_q <= 1'b0;
            cap_addr_q     <= '0;
            cap_wdata_q    <= '0;
            cap_pc_q       <= '0;
            cap_rd_q       <= '0;
            ma_valid_q     <= 1'b0;
            pc_q           <= '0;
            rd_q           <= '0;
            data_q         <= '0;
            exc_q          <= 1'b0;
            cause_q        <= '0;
        end else begin
            state_q        <= state_d;
            cap_op_q       <= cap_op_d;
            cap_size_q     <= cap_size_d;
            cap_unsigned_q <= cap_unsigned_d;
            cap_addr_q     <= cap_addr_d;
            cap_wdata_q    <= cap_wdata_d;
            cap_pc_q       <= cap_pc_d;
            cap_rd_q       <= cap_rd_d;
            ma_valid_q     <= ma_valid_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
            exc_q          <= exc_d;
            cause_q        <= cause_d;
        end
    end

    // Handshake and stall outputs decode the state register directly, so
    // stall drops in the same cycle the retire pulse appears.
    assign stall     = (state_q != IDLE);
    assign a_valid   = (state_q == REQ);
    assign d_ready   = (state_q == RESP);

    assign ma_valid  = ma_valid_q;
    assign pc        = pc_q;
    assign rd        = rd_q;
    assign data      = data_q;
    assign exc       = exc_q;
    assign exc_cause = cause_q;

    assign a_opcode  = (cap_op_q == OP_LOAD) ? TL_GET : TL_PUTFULL;
    assign a_size    = {1'b0, cap_size_q};
    assign a_source  = 4'(SRC_ID);
    assign a_address = cap_addr_q;
    assign a_mask    = lane_mask(cap_size_q, cap_addr_q[2:0]);
    assign a_data    = replicate_wdata(cap_size_q, cap_wdata_q);

endmodule

// File: tb/tb_access_stage.sv
// Scoreboard bench for access_stage: the driver issues instructions and plays
// the TileLink fabric, pushing expected retire results and A-channel requests
// (from a byte-level reference model) into queues; monitors pop and compare.
module tb_access_stage;

    localparam int unsigned SRC = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [63:0] ex_pc = '0;
    logic [4:0]  ex_rd = '0;
    logic [63:0] ex_result = '0;
    logic [63:0] ex_wdata = '0;
    logic [1:0]  ex_op = '0;
    logic [1:0]  ex_size = '0;
    logic        ex_unsigned = 1'b0;
    logic        stall, ma_valid, exc;
    logic [63:0] pc, data;
    logic [4:0]  rd;
    logic [3:0]  exc_cause;
    logic        a_valid, a_ready = 1'b0;
    logic [2:0]  a_opcode, a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address, a_data;
    logic [7:0]  a_mask;
    logic        d_valid = 1'b0, d_ready;
    logic [2:0]  d_opcode = '0;
    logic        d_denied = 1'b0;
    logic [63:0] d_data = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        exc;
        logic [3:0]  cause;
        bit          chk_data;
    } out_t;

    typedef struct {
        logic [2:0]  opc;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        bit          chk_data;
    } a_t;

    out_t exp_q[$];
    a_t   a_q[$];

    access_stage #(.SRC_ID(SRC), .SIGN_EXT_DEFAULT(1)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_wdata(ex_wdata), .ex_op(ex_op), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .stall(stall), .ma_valid(ma_valid), .pc(pc), .rd(rd), .data(data),
        .exc(exc), .exc_cause(exc_cause),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_denied(d_denied), .d_data(d_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_load(logic [63:0] beat, int off, int n, bit sgn);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = beat[8*(off+i) +: 8];
        if (sgn && n < 8 && v[8*n-1]) begin
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [7:0] model_mask(int off, int n);
        logic [7:0] m = '0;
        for (int i = 0; i < n; i++) m[off+i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_adata(logic [63:0] wd, int n);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
        return v;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ma_valid) begin
                check("stall low with ma_valid", {63'd0, stall}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected ma_valid", {63'd0, ma_valid}, 64'd0);
                end else begin
                    out_t e;
                    e = exp_q.pop_front();
                    check("retire pc", pc, e.pc);
                    check("retire rd", {59'd0, rd}, {59'd0, e.rd});
                    check("retire exc", {63'd0, exc}, {63'd0, e.exc});
                    check("retire cause", {60'd0, exc_cause}, {60'd0, e.cause});
                    if (e.chk_data) check("retire data", data, e.data);
                end
            end
            if (a_valid) begin
                if (a_q.size() == 0) begin
                    check("unexpected a_valid", {63'd0, a_valid}, 64'd0);
                end else begin
                    check("a_opcode", {61'd0, a_opcode}, {61'd0, a_q[0].opc});
                    check("a_size", {61'd0, a_size}, {61'd0, a_q[0].size});
                    check("a_source", {60'd0, a_source}, 64'(SRC));
                    check("a_address", a_address, a_q[0].addr);
                    check("a_mask", {56'd0, a_mask}, {56'd0, a_q[0].mask});
                    if (a_q[0].chk_data) check("a_data", a_data, a_q[0].data);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && a_valid && a_ready && a_q.size() > 0) void'(a_q.pop_front());
    end

    // ---------------- driver + fabric ----------------
    task automatic wait_idle();
        int w = 0;
        while (stall && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (stall) check("wait for stall release", {63'd0, stall}, 64'd0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic uns, input logic [4:0] rd_i,
                         input logic [63:0] pc_i, input int a_dly, input int d_dly,
                         input logic [63:0] beat, input logic denied, input logic [2:0] dopc,
                         input bit spurious);
        int n, off, w;
        bit misal, fault;
        out_t e;
        a_t ae;
        n = 1 << size;
        off = int'(addr[2:0]);
        misal = (addr % n) != 0;
        wait_idle();

        ex_valid = 1'b1; ex_op = op; ex_size = size; ex_result = addr;
        ex_wdata = wdata; ex_unsigned = uns; ex_rd = rd_i; ex_pc = pc_i;

        e.pc = pc_i; e.chk_data = 1'b1;
        if (op != 2'd1 && op != 2'd2) begin
            e.rd = rd_i; e.data = addr; e.exc = 1'b0; e.cause = 4'd0;
        end else if (misal) begin
            e.rd = 5'd0; e.data = '0; e.exc = 1'b1; e.chk_data = 1'b0;
            e.cause = (op == 2'd1) ? 4'd4 : 4'd6;
        end else begin
            fault = denied || (op == 2'd1 ? dopc != 3'd1 : dopc != 3'd0);
            if (fault) begin
                e.rd = 5'd0; e.data = '0; e.exc = 1'b1;
                e.cause = (op == 2'd1) ? 4'd5 : 4'd7;
            end else begin
                e.exc = 1'b0; e.cause = 4'd0;
                e.rd = (op == 2'd1) ? rd_i : 5'd0;
                e.data = (op == 2'd1) ? model_load(beat, off, n, !uns) : 64'd0;
            end
            ae.opc = (op == 2'd1) ? 3'd4 : 3'd0;
            ae.size = {1'b0, size};
            ae.addr = addr;
            ae.mask = model_mask(off, n);
            ae.data = model_adata(wdata, n);
            ae.chk_data = (op == 2'd2);
            a_q.push_back(ae);
        end
        exp_q.push_back(e);

        @(negedge clk);
        ex_valid = 1'b0;
        if ((op != 2'd1 && op != 2'd2) || misal) begin
            check("latency-1 ma_valid", {63'd0, ma_valid}, 64'd1);
            check("no bus traffic", {63'd0, a_valid}, 64'd0);
            check("stall stays low", {63'd0, stall}, 64'd0);
            return;
        end

        check("a_valid one cycle after capture", {63'd0, a_valid}, 64'd1);
        check("stall busy", {63'd0, stall}, 64'd1);
        for (int i = 0; i < a_dly; i++) begin
            if (spurious) begin
                d_valid = 1'b1; d_data = {$urandom, $urandom}; d_denied = 1'b1; d_opcode = 3'd1;
            end
            @(negedge clk);
            d_valid = 1'b0;
            check("a_valid held while a_ready low", {63'd0, a_valid}, 64'd1);
            check("d_ready low in REQ", {63'd0, d_ready}, 64'd0);
        end
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        check("a_valid drops after handshake", {63'd0, a_valid}, 64'd0);
        for (int i = 0; i < d_dly; i++) begin
            @(negedge clk);
        end
        w = 0;
        while (!d_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("d_ready in RESP", {63'd0, d_ready}, 64'd1);
        check("stall while waiting for D", {63'd0, stall}, 64'd1);
        d_valid = 1'b1; d_data = beat; d_denied = denied; d_opcode = dopc;
        @(negedge clk);
        d_valid = 1'b0; d_denied = 1'b0;
        check("ma_valid after D beat", {63'd0, ma_valid}, 64'd1);
    endtask

    task automatic check_all_zero();
        check("rst stall", {63'd0, stall}, 64'd0);
        check("rst ma_valid", {63'd0, ma_valid}, 64'd0);
        check("rst a_valid", {63'd0, a_valid}, 64'd0);
        check("rst d_ready", {63'd0, d_ready}, 64'd0);
        check("rst pc", pc, 64'd0);
        check("rst rd", {59'd0, rd}, 64'd0);
        check("rst data", data, 64'd0);
        check("rst exc", {63'd0, exc}, 64'd0);
        check("rst cause", {60'd0, exc_cause}, 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero();
        rst = 1'b0;

        // Pass-through
        do_op(2'd0, 2'd0, 64'h1234, '0, 1'b0, 5'd5, 64'h8000_0000, 0, 0, '0, 1'b0, 3'd0, 0);
        // lw 0x1004 signed -> upper word 0xFFFF8000 sign-extended
        do_op(2'd1, 2'd2, 64'h1004, '0, 1'b0, 5'd7, 64'h8000_0004, 0, 0,
              64'hFFFF8000_00000000, 1'b0, 3'd1, 0);
        // sb 0x2003 with a_ready held low 3 cycles
        do_op(2'd2, 2'd0, 64'h2003, 64'hAB, 1'b0, 5'd9, 64'h8000_0008, 3, 0,
              '0, 1'b0, 3'd0, 1);
        // lh misaligned
        do_op(2'd1, 2'd1, 64'h3001, '0, 1'b0, 5'd3, 64'h8000_000C, 0, 0, '0, 1'b0, 3'd1, 0);
        // sw misaligned
        do_op(2'd2, 2'd2, 64'h4002, 64'h55, 1'b0, 5'd4, 64'h8000_0010, 0, 0, '0, 1'b0, 3'd0, 0);
        // ld denied
        do_op(2'd1, 2'd3, 64'h5000, '0, 1'b0, 5'd6, 64'h8000_0014, 1, 2,
              64'h0123_4567_89AB_CDEF, 1'b1, 3'd1, 0);
        // load answered with AccessAck -> fault
        do_op(2'd1, 2'd0, 64'h5001, '0, 1'b0, 5'd6, 64'h8000_0018, 0, 1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 0);
        // sd denied
        do_op(2'd2, 2'd3, 64'h6008, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 5'd1, 64'h8000_001C, 0, 0,
              '0, 1'b1, 3'd0, 0);
        // lbu at top lane
        do_op(2'd1, 2'd0, 64'h7007, '0, 1'b1, 5'd31, 64'h8000_0020, 0, 0,
              64'h9A00_0000_0000_0000, 1'b0, 3'd1, 0);

        for (int k = 0; k < 200; k++) begin
            logic [63:0] addr, beat, wd;
            logic [1:0]  op, sz;
            op = 2'($urandom_range(2));
            sz = 2'($urandom_range(3));
            addr = {$urandom, $urandom};
            if ($urandom_range(3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            beat = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            do_op(op, sz, addr, wd, 1'($urandom_range(1)), 5'($urandom), {$urandom, $urandom},
                  int'($urandom_range(3)), int'($urandom_range(2)), beat,
                  1'($urandom_range(7) == 0), (op == 2'd1) ? 3'd1 : 3'd0,
                  bit'($urandom_range(1)));
        end

        // Reset while in RESP: captured op discarded, no retire pulse.
        wait_idle();
        begin
            a_t ae;
            ex_valid = 1'b1; ex_op = 2'd1; ex_size = 2'd3; ex_result = 64'h9000;
            ex_rd = 5'd12; ex_pc = 64'h8000_1000; ex_unsigned = 1'b0;
            ae.opc = 3'd4; ae.size = 3'd3; ae.addr = 64'h9000; ae.mask = 8'hFF;
            ae.data = '0; ae.chk_data = 1'b0;
            a_q.push_back(ae);
            @(negedge clk);
            ex_valid = 1'b0;
            a_ready = 1'b1;
            @(negedge clk);
            a_ready = 1'b0;
            check("in RESP before reset", {63'd0, d_ready}, 64'd1);
            rst = 1'b1;
            d_valid = 1'b1; d_data = 64'h1111; d_opcode = 3'd1;
            @(negedge clk);
            d_valid = 1'b0;
            check_all_zero();
            rst = 1'b0;
        end
        do_op(2'd0, 2'd0, 64'hCAFE, '0, 1'b0, 5'd8, 64'h8000_2000, 0, 0, '0, 1'b0, 3'd0, 0);

        repeat (5) @(negedge clk);
        check("retire queue drained", 64'(exp_q.size()), 64'd0);
        check("A queue drained", 64'(a_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
